mult_iter_param: RTL and testbench

//  Parametrised iterative unsigned/signed multiplier, WIDTH x WIDTH -> 2*WIDTH.

---
 rtl/mult_iter_pkg.sv | 15 +
 rtl/mult_iter_arith.sv | 70 +++++++
 rtl/mult_iter_param.sv | 108 ++++++++++
 tb/tb_mult_iter_param.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_iter_pkg.sv
// Shared types and elaboration helpers for the iterative multiplier.
package mult_iter_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  // Partial products per operation: one per (digit of a, digit of b) pair.
  function automatic int unsigned n_iter(input int unsigned width, input int unsigned chunk);
    return (width / chunk) * (width / chunk);
  endfunction

  function automatic bit chunk_ok(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/mult_iter_arith.sv
// Datapath of the iterative multiplier: operand/sign latches, digit select,
// digit multiplier, shifted accumulation and final sign fix-up.
module mult_iter_arith
  import mult_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned DW    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               ld_op,
  input  logic               clr_prod,
  input  logic               upd_prod,
  input  logic               fix_sign,
  input  logic [DW-1:0]      dig_a,
  input  logic [DW-1:0]      dig_b,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   a_q, b_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] prod_q;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [CHUNK-1:0]   da, db;
  logic [2*CHUNK-1:0] pp;
  logic [2*WIDTH-1:0] pp_ext;
  int unsigned        shamt;

  // The most negative value maps to 2^(WIDTH-1), still representable unsigned.
  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  always_comb begin
    da     = a_q[dig_a*CHUNK +: CHUNK];
    db     = b_q[dig_b*CHUNK +: CHUNK];
    pp     = {{CHUNK{1'b0}}, da} * {{CHUNK{1'b0}}, db};
    pp_ext = (2*WIDTH)'(pp);
    shamt  = CHUNK * (32'(dig_a) + 32'(dig_b));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      neg_q  <= 1'b0;
      prod_q <= '0;
    end else begin
      if (ld_op) begin
        a_q   <= a_mag;
        b_q   <= b_mag;
        neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      end
      if (clr_prod) begin
        prod_q <= '0;
      end else if (upd_prod) begin
        prod_q <= prod_q + (pp_ext << shamt);
      end else if (fix_sign && neg_q) begin
        prod_q <= -prod_q;
      end
    end
  end

  assign product = prod_q;

endmodule

// File: rtl/mult_iter_param.sv
// Parametrised iterative WIDTH x WIDTH multiplier: FSM, digit counter and
// busy/done generation around the mult_iter_arith datapath.
module mult_iter_param
  import mult_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  if (!chunk_ok(WIDTH, CHUNK)) begin : gen_bad_chunk
    $error("mult_iter_param: WIDTH must be a non-zero multiple of CHUNK");
  end

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned NIter = n_iter(WIDTH, CHUNK);
  localparam int unsigned CW    = (NIter > 1) ? $clog2(NIter) : 1;
  localparam int unsigned DW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(NIter - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            ld_op, clr_prod, upd_prod, fix_sign;
  logic [DW-1:0]   dig_a, dig_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    ld_op    = 1'b0;
    clr_prod = 1'b0;
    upd_prod = 1'b0;
    fix_sign = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ld_op    = 1'b1;
          clr_prod = 1'b1;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        upd_prod = 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StFinish;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFinish: begin
        fix_sign = 1'b1;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counter walks b's digits fastest: i = cnt / N, j = cnt % N.
  assign dig_a = DW'(cnt_q / CW'(N));
  assign dig_b = DW'(cnt_q % CW'(N));

  assign busy = (state_q != StIdle);
  assign done = done_q;

  mult_iter_arith #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK),
    .DW    (DW)
  ) u_arith (
    .clk       (clk),
    .reset     (reset),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .ld_op     (ld_op),
    .clr_prod  (clr_prod),
    .upd_prod  (upd_prod),
    .fix_sign  (fix_sign),
    .dig_a     (dig_a),
    .dig_b     (dig_b),
    .product   (product)
  );

endmodule

// File: tb/tb_mult_iter_param.sv
// Scoreboard bench for mult_iter_param at 32/8 and 16/16 configurations.
module tb_mult_iter_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start = 1'b0, is_signed = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [63:0] product;

  logic        start16 = 1'b0, sgn16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [31:0] product16;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mult_iter_param #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  mult_iter_param #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .is_signed(sgn16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(product16)
  );

  function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    logic signed [63:0] sx, sy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic s);
    logic signed [31:0] sx, sy;
    if (s) begin
      sx = {{16{x[15]}}, x};
      sy = {{16{y[15]}}, y};
      return sx * sy;
    end
    return {16'b0, x} * {16'b0, y};
  endfunction

  // Drives one request, scrambles the inputs afterwards, and waits for done.
  // A second start (a=b=9) is pulsed at loop index glitch_at while busy.
  task automatic op32(input logic [31:0] x, input logic [31:0] y, input logic s,
                      input int glitch_at, output logic [63:0] prod,
                      output int busy_cyc, output bit timeout);
    start = 1'b1; a = x; b = y; is_signed = s;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; is_signed = ~s;
    busy_cyc = 0;
    timeout  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        timeout = 1'b0;
        break;
      end
      if (busy) busy_cyc++;
      if (k == glitch_at) begin
        start = 1'b1; a = 32'd9; b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    prod  = product;
  endtask

  task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic s,
                      output logic [31:0] prod, output int busy_cyc, output bit timeout);
    start16 = 1'b1; a16 = x; b16 = y; sgn16 = s;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    busy_cyc = 0;
    timeout  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (done16) begin
        timeout = 1'b0;
        break;
      end
      if (busy16) busy_cyc++;
      @(posedge clk); #1;
    end
    prod = product16;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({busy, done, product} !== 66'd0) begin
      tests_failed++;
      $display("FAIL reset32: busy=%b done=%b product=%h, want all zero", busy, done, product);
    end
    tests_run++;
    if ({busy16, done16, product16} !== 34'd0) begin
      tests_failed++;
      $display("FAIL reset16: busy=%b done=%b product=%h, want all zero",
               busy16, done16, product16);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_unsigned_max();
    logic [63:0] p, e;
    int bc;
    bit to;
    exp_q.push_back(64'hFFFFFFFE00000001);
    op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, p, bc, to);
    e = exp_q.pop_front();
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("FAIL max_timeout: done not seen, got none, want pulse");
    end
    tests_run++;
    if (p !== e) begin
      tests_failed++;
      $display("FAIL max_product: got %h want %h", p, e);
    end
    tests_run++;
    if (bc !== 17) begin
      tests_failed++;
      $display("FAIL max_busy_cycles: got %0d want 17", bc);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_in_done_cycle: got %b want 0", busy);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || product !== e) begin
      tests_failed++;
      $display("FAIL done_pulse_hold: done=%b product=%h want 0 %h", done, product, e);
    end
  endtask

  task automatic test_signed();
    logic [31:0] xs[5] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'h00000007};
    logic [31:0] ys[5] = '{32'h00000007, 32'h00000007, 32'h80000000, 32'h00000001, 32'hFFFFFFFD};
    logic        ss[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [63:0] es[5] = '{64'hFFFFFFFFFFFFFFEB, 64'h00000006FFFFFFEB, 64'h4000000000000000,
                           64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFEB};
    logic [63:0] p, e;
    int bc;
    bit to;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(es[i]);
      op32(xs[i], ys[i], ss[i], -1, p, bc, to);
      e = exp_q.pop_front();
      tests_run++;
      if (to || p !== e) begin
        tests_failed++;
        $display("FAIL signed_case%0d: got %h timeout=%b want %h", i, p, to, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] p, e;
    int bc;
    bit to;
    exp_q.push_back(64'd30);
    op32(32'd5, 32'd6, 1'b0, 3, p, bc, to);
    e = exp_q.pop_front();
    tests_run++;
    if (to || p !== e) begin
      tests_failed++;
      $display("FAIL start_while_busy: got %0d timeout=%b want %0d", p, to, e);
    end
    tests_run++;
    if (bc !== 17) begin
      tests_failed++;
      $display("FAIL busy_with_glitch: got %0d want 17", bc);
    end
    // Still in the done cycle: this start must be taken without a bubble.
    exp_q.push_back(64'd81);
    op32(32'd9, 32'd9, 1'b0, -1, p, bc, to);
    e = exp_q.pop_front();
    tests_run++;
    if (to || p !== e || bc !== 17) begin
      tests_failed++;
      $display("FAIL back_to_back: got %0d busy=%0d want %0d busy=17", p, bc, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [63:0] p, e;
    int bc;
    bit to;
    start = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1 || product === 64'd0) begin
      tests_failed++;
      $display("FAIL pre_abort: busy=%b product=%h want busy=1 partial!=0", busy, product);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, product} !== 66'd0) begin
      tests_failed++;
      $display("FAIL async_abort: busy=%b done=%b product=%h want all zero",
               busy, done, product);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.push_back(64'd6);
    op32(32'd2, 32'd3, 1'b0, -1, p, bc, to);
    e = exp_q.pop_front();
    tests_run++;
    if (to || p !== e || bc !== 17) begin
      tests_failed++;
      $display("FAIL after_abort: got %0d busy=%0d want %0d busy=17", p, bc, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random32();
    logic [31:0] x, y;
    logic s;
    logic [63:0] p, e;
    int bc;
    bit to;
    for (int i = 0; i < 8; i++) begin
      x = (i % 4 == 0) ? 32'd0 : $urandom;
      y = (i % 3 == 1) ? 32'd0 : $urandom;
      s = 1'($urandom);
      exp_q.push_back(ref32(x, y, s));
      op32(x, y, s, -1, p, bc, to);
      e = exp_q.pop_front();
      tests_run++;
      if (to || p !== e || bc !== 17) begin
        tests_failed++;
        $display("FAIL rand32_%0d: a=%h b=%h s=%b got %h busy=%0d want %h busy=17",
                 i, x, y, s, p, bc, e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_chunk();
    logic [15:0] x, y;
    logic s;
    logic [31:0] p;
    logic [63:0] e;
    int bc;
    bit to;
    exp_q.push_back(64'h0001FFFE);
    op16(16'hFFFF, 16'h0002, 1'b0, p, bc, to);
    e = exp_q.pop_front();
    tests_run++;
    if (to || {32'b0, p} !== e) begin
      tests_failed++;
      $display("FAIL w16_product: got %h want %h", p, e);
    end
    tests_run++;
    if (bc !== 2) begin
      tests_failed++;
      $display("FAIL w16_busy_cycles: got %0d want 2", bc);
    end
    for (int i = 0; i < 24; i++) begin
      x = (i % 5 == 0) ? 16'd0 : 16'($urandom);
      y = (i % 7 == 3) ? 16'd0 : 16'($urandom);
      if (i == 1) begin x = 16'h8000; y = 16'h8000; end
      s = 1'($urandom);
      exp_q.push_back({32'b0, ref16(x, y, s)});
      op16(x, y, s, p, bc, to);
      e = exp_q.pop_front();
      tests_run++;
      if (to || {32'b0, p} !== e) begin
        tests_failed++;
        $display("FAIL rand16_%0d: a=%h b=%h s=%b got %h want %h", i, x, y, s, p, e[31:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_back_to_back();
    test_reset_abort();
    test_random32();
    test_single_chunk();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
